fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that lets NUM_REQ producers share one 32-entry FIFO buffer write port.
- Accepts beats from the producers over valid/ready handshakes.
- Registers the granted beat into a single output stage and drives the FIFO write_enable/data_in pair.
- Holds a beat while the FIFO reports full.
- Owns the FIFO full_tresh configuration register.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-side arbiter.
//   state_t       : arbiter FSM encoding (IDLE / ACTIVE / STALL)
//   FIFO_DEPTH_C  : FIFO capacity; upper clamp for the full threshold
//   THRESH_W_C    : width of the full-threshold field
//   MAX_BURST_C   : default burst length when FIFO_ARB_BURST_EN is defined
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  localparam int FIFO_DEPTH_C = 32;
  localparam int THRESH_W_C   = 6;
  localparam int MAX_BURST_C  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   N      : number of requesters
//   req    : request vector
//   ptr    : index where the search starts (wraps modulo N)
//   grant  : one-hot winner (all zero when no request)
//   idx    : index of the winner (0 when no request)
//   any    : at least one request is set
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    idx  = '0;
    cand = 0;
    any  = |req;
    // Walk offsets from farthest to nearest so the candidate closest to ptr
    // is the last one written and therefore wins.
    for (int i = N - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % N;
      if (req[cand]) begin
        idx = IDX_W'(cand);
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter letting NUM_REQ producers share one
// FIFO write port through a single registered output stage.
//
// Optional feature macro: FIFO_ARB_BURST_EN. When defined, a winning producer
// keeps the grant for up to MAX_BURST consecutive beats while its req_valid
// stays high. When undefined, arbitration is single-beat round-robin.
//
// Handshake: a producer beat transfers in any cycle where req_valid[i] and
// req_ready[i] are both high; producers hold req_valid/req_data stable until
// that happens. req_ready is one-hot and never depends on req_ready itself.
// The FIFO write transfers in any cycle where fifo_write_enable is high and
// fifo_full is low; otherwise the beat is held unchanged.
//
// Ports:
//   clock, reset_n        : clock, synchronous active-low reset
//   req_valid/req_data    : producer beats, lane i at [i*DATA_W +: DATA_W]
//   req_ready             : one-hot accept strobe
//   fifo_full             : FIFO full status
//   fifo_write_enable     : FIFO write request (output stage occupied)
//   fifo_data_in          : FIFO write data
//   fifo_full_tresh       : FIFO full threshold register
//   cfg_tresh/_load       : threshold value and single-cycle load strobe
//   grant_id              : producer whose beat sits in the output stage
//   stall                 : output stage occupied while FIFO is full
//   fsm_state             : current FSM state (debug visibility)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int THRESH_W   = THRESH_W_C,
  parameter int FIFO_DEPTH = FIFO_DEPTH_C
`ifdef FIFO_ARB_BURST_EN
  , parameter int MAX_BURST = MAX_BURST_C
`endif
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_write_enable,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [THRESH_W-1:0]         fifo_full_tresh,
  input  logic [THRESH_W-1:0]         cfg_tresh,
  input  logic                        cfg_tresh_load,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        stall,
  output state_t                      fsm_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // The registered state only records occupancy (IDLE / ACTIVE). STALL is
  // an occupied stage seen together with the live fifo_full, so stall and
  // req_ready react in the same cycle the FIFO reports full.
  state_t state_q, state_d, cur_state;

  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   win;
  logic               out_valid;
  logic               complete;
  logic               can_load;
  logic               accept;
  logic [THRESH_W-1:0] tresh_d;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  // burst_cnt counts beats after the first one of the current grant.
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_open;
  logic             hold;

  assign hold = burst_open && req_valid[grant_id]
                && (burst_cnt < CNT_W'(MAX_BURST - 1));
  assign win  = hold ? grant_id : pick_idx;
`else
  assign win  = pick_idx;
`endif

  assign out_valid         = (state_q != IDLE);
  assign fifo_write_enable = out_valid;
  assign complete          = out_valid && !fifo_full;
  assign can_load          = !out_valid || complete;
  // Gated by reset_n so no beat is handshaken into a register being cleared.
  assign accept            = can_load && pick_any && reset_n;
  assign stall             = (cur_state == STALL);
  assign fsm_state         = cur_state;

  always_comb begin
    req_ready = '0;
    if (accept) begin
`ifdef FIFO_ARB_BURST_EN
      req_ready = hold ? (NUM_REQ'(1) << grant_id) : pick_grant;
`else
      req_ready = pick_grant;
`endif
    end
  end

  always_comb begin
    cur_state = state_q;
    if (state_q != IDLE) begin
      cur_state = fifo_full ? STALL : ACTIVE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (cur_state)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE:  if (!accept) state_d = IDLE;    // write completes this cycle
      STALL:   state_d = ACTIVE;               // beat stays in the stage
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tresh_d = cfg_tresh;
    if (cfg_tresh == '0) begin
      tresh_d = THRESH_W'(1);
    end else if (cfg_tresh > THRESH_W'(FIFO_DEPTH)) begin
      tresh_d = THRESH_W'(FIFO_DEPTH);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fifo_data_in <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fifo_data_in <= req_data[int'(win)*DATA_W +: DATA_W];
        grant_id     <= win;
        rr_ptr       <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fifo_full_tresh <= THRESH_W'(FIFO_DEPTH);
    end else if (cfg_tresh_load) begin
      fifo_full_tresh <= tresh_d;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      burst_cnt  <= '0;
      burst_open <= 1'b0;
    end else if (accept) begin
      burst_cnt  <= hold ? burst_cnt + 1'b1 : '0;
      burst_open <= 1'b1;
    end else if (can_load) begin
      // Nobody requesting at an opportunity: any open burst is over.
      burst_cnt  <= '0;
      burst_open <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_enable;
  logic [7:0]  fifo_data_in;
  logic [5:0]  fifo_full_tresh;
  logic [5:0]  cfg_tresh;
  logic        cfg_tresh_load;
  logic [1:0]  grant_id;
  logic        stall;
  state_t      fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];

  localparam logic [31:0] LANES = {8'h44, 8'h33, 8'h22, 8'h11};

  fifo_wr_arbiter dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .fifo_full         (fifo_full),
    .fifo_write_enable (fifo_write_enable),
    .fifo_data_in      (fifo_data_in),
    .fifo_full_tresh   (fifo_full_tresh),
    .cfg_tresh         (cfg_tresh),
    .cfg_tresh_load    (cfg_tresh_load),
    .grant_id          (grant_id),
    .stall             (stall),
    .fsm_state         (fsm_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // FIFO-side monitor: every write the FIFO would actually take.
  always @(posedge clock) begin
    if (fifo_write_enable && !fifo_full) wr_q.push_back(fifo_data_in);
  end

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 4'hF; req_data = LANES;
    fifo_full = 1'b0; cfg_tresh = '0; cfg_tresh_load = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", fifo_write_enable); end
    n_cmp++; if (fifo_data_in !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", fifo_data_in); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    n_cmp++; if (fifo_full_tresh !== 6'd32) begin n_err++; $display("FAIL reset_tresh: got %0d want 32", fifo_full_tresh); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
  endtask

  task automatic test_round_robin;
    logic [1:0] id;
    reset_n = 1'b1; req_valid = 4'hF; req_data = LANES;
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      #1;
      n_cmp++; if (req_ready !== (4'b0001 << id)) begin n_err++; $display("FAIL rr_ready k=%0d: got %b want %b", k, req_ready, 4'b0001 << id); end
      exp_q.push_back(8'h11 * (8'(id) + 8'd1));
      @(negedge clock);
      n_cmp++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL rr_we k=%0d: got %b want 1", k, fifo_write_enable); end
      n_cmp++; if (grant_id !== id) begin n_err++; $display("FAIL rr_grant k=%0d: got %0d want %0d", k, grant_id, id); end
      n_cmp++; if (fifo_data_in !== 8'h11 * (8'(id) + 8'd1)) begin n_err++; $display("FAIL rr_data k=%0d: got %h want %h", k, fifo_data_in, 8'h11 * (8'(id) + 8'd1)); end
    end
    req_valid = 4'h0;
    @(negedge clock);
    n_cmp++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL rr_drain_we: got %b want 0", fifo_write_enable); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL rr_drain_state: got %0d want IDLE", fsm_state); end
  endtask

  // rr_ptr is 1 here; only producer 2 requests.
  task automatic test_single;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    exp_q.push_back(8'hA5);
    @(negedge clock);
    req_valid = 4'b0000;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_after: got %b want 0000", req_ready); end
    n_cmp++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL single_we: got %b want 1", fifo_write_enable); end
    n_cmp++; if (fifo_data_in !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", fifo_data_in); end
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    @(negedge clock);
    n_cmp++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL single_drain_we: got %b want 0", fifo_write_enable); end
  endtask

  // rr_ptr is 3 here; producers 0 and 1 request, search wraps to 0.
  task automatic test_stall;
    req_data = LANES;
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL stall_first_ready: got %b want 0001", req_ready); end
    exp_q.push_back(8'h11);
    @(negedge clock);
    fifo_full = 1'b1; req_valid = 4'b0010;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL stall_enter: got %b want 1", stall); end
    n_cmp++; if (fsm_state !== STALL) begin n_err++; $display("FAIL stall_state: got %0d want STALL", fsm_state); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL stall_hold k=%0d: got %b want 1", k, stall); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready k=%0d: got %b want 0000", k, req_ready); end
      n_cmp++; if (fifo_data_in !== 8'h11) begin n_err++; $display("FAIL stall_data k=%0d: got %h want 11", k, fifo_data_in); end
      n_cmp++; if (fifo_write_enable !== 1'b1) begin n_err++; $display("FAIL stall_we k=%0d: got %b want 1", k, fifo_write_enable); end
    end
    fifo_full = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", stall); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL stall_b2b_ready: got %b want 0010", req_ready); end
    exp_q.push_back(8'h22);
    @(negedge clock);
    req_valid = 4'b0000;
    n_cmp++; if (fifo_data_in !== 8'h22) begin n_err++; $display("FAIL stall_next_data: got %h want 22", fifo_data_in); end
    n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL stall_next_grant: got %0d want 1", grant_id); end
    n_cmp++; if (fsm_state !== ACTIVE) begin n_err++; $display("FAIL stall_next_state: got %0d want ACTIVE", fsm_state); end
    @(negedge clock);
    n_cmp++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL stall_drain_we: got %b want 0", fifo_write_enable); end
  endtask

  task automatic test_thresh;
    logic [5:0] vals [4] = '{6'd0, 6'd40, 6'd10, 6'd33};
    logic [5:0] want [4] = '{6'd1, 6'd32, 6'd10, 6'd32};
    for (int k = 0; k < 4; k++) begin
      cfg_tresh = vals[k]; cfg_tresh_load = 1'b1;
      @(negedge clock);
      cfg_tresh_load = 1'b0; cfg_tresh = 6'd5;
      @(negedge clock);
      n_cmp++; if (fifo_full_tresh !== want[k]) begin n_err++; $display("FAIL tresh k=%0d: got %0d want %0d", k, fifo_full_tresh, want[k]); end
    end
    cfg_tresh = 6'd10; cfg_tresh_load = 1'b1;
    @(negedge clock);
    cfg_tresh_load = 1'b0;
  endtask

  // rr_ptr is 2 here; producer 2's beat is parked in STALL, then reset.
  task automatic test_reset_in_stall;
    req_data = {8'h44, 8'h5A, 8'h22, 8'h11};
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rst_stall_ready: got %b want 0100", req_ready); end
    @(negedge clock);
    fifo_full = 1'b1; req_valid = 4'b0000;
    @(negedge clock);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_stall: got %b want 1", stall); end
    reset_n = 1'b0;
    @(negedge clock);
    n_cmp++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL rst_stall_we: got %b want 0", fifo_write_enable); end
    n_cmp++; if (fifo_full_tresh !== 6'd32) begin n_err++; $display("FAIL rst_stall_tresh: got %0d want 32", fifo_full_tresh); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_stall_after: got %b want 0", stall); end
    reset_n = 1'b1; fifo_full = 1'b0; req_data = LANES; req_valid = 4'hF;
    #1;
    // rr_ptr back at 0: producer 0 wins, not producer 3.
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_stall_ptr: got %b want 0001", req_ready); end
    exp_q.push_back(8'h11);
    @(negedge clock);
    req_valid = 4'h0;
    @(negedge clock);
    n_cmp++; if (fifo_write_enable !== 1'b0) begin n_err++; $display("FAIL rst_stall_drain: got %b want 0", fifo_write_enable); end
  endtask

`ifdef FIFO_ARB_BURST_EN
  task automatic test_burst;
    logic [3:0] pat [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    reset_n = 1'b0; req_valid = 4'h0;
    @(negedge clock);
    reset_n = 1'b1; req_data = LANES; req_valid = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      #1;
      n_cmp++; if (req_ready !== pat[k]) begin n_err++; $display("FAIL burst k=%0d: got %b want %b", k, req_ready, pat[k]); end
      exp_q.push_back(pat[k] == 4'b0001 ? 8'h11 : 8'h22);
      @(negedge clock);
    end
    req_valid = 4'h0;
    @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_thresh();
    test_reset_in_stall();
`ifdef FIFO_ARB_BURST_EN
    test_burst();
`endif
    repeat (2) @(negedge clock);
    // scoreboard: FIFO-side writes against the expected beat stream
    n_cmp++;
    if (wr_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL sb_count: got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL sb_data idx=%0d: got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
